load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sits between the core's execute stage and dmem; translates byte-addressed RV32I loads/stores
//  (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses on the word-organised dmem array.
//  Byte/half stores use a read-modify-write sequence, and loads are extracted and sign/zero-extended.
//  Misaligned or illegal accesses return an error without touching memory.
//  Single outstanding request; the core stalls on busy.
// PARAMETERS
//  XLEN  32  data/address width
//  AW    10  dmem word-index width (matches 1<<10-entry dmem)
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  rst        in   1     synchronous, active-high reset
//  req        in   1     request strobe; sampled only when busy=0
//  we         in   1     1=store, 0=load
//  funct3     in   3     RV32I width/sign code (000 B,001 H,010 W,100 BU,101 HU)
//  addr       in   XLEN  byte address (ALU result)
//  wdata      in   XLEN  store data (rs2)
//  busy       out  1     high while a request is in flight (state!=IDLE)
//  ack        out  1     one-cycle completion pulse
//  err        out  1     valid with ack; misaligned/illegal funct3
//  rdata      out  XLEN  extended load data; valid with ack, held until next ack
//  mem_addr   out  AW    dmem word index = addr_q[AW+1:2] (upper bits dropped, wraps)
//  mem_we     out  1     dmem write enable (MemRW)
//  mem_wdata  out  XLEN  dmem write data (DataW)
//  mem_rdata  in   XLEN  dmem read data (DataR, combinational from mem_addr)
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, ack=0, err=0, rdata=0, mem_addr=0, mem_wdata=0, mem_we=0.
//  - Accept in IDLE when req=1: latch we, funct3, addr, wdata into *_q. req ignored while busy.
//  - Legality: W needs addr[1:0]=00; H/HU needs addr[0]=0; B/BU always aligned.
//    funct3 011/110/111 illegal; stores with funct3 100/101 illegal.
//  - FSM states: IDLE, LD, RMW_RD, WR, RESP.
//    IDLE -req&illegal-> RESP(err=1)    IDLE -req&load-> LD
//    IDLE -req&SW-> WR                  IDLE -req&SB/SH-> RMW_RD
//    LD -> RESP: rdata <= extend(lane of mem_rdata) at end of LD
//    RMW_RD -> WR: merge_q <= mem_rdata with selected byte/half replaced by wdata_q low bits
//    WR -> RESP: mem_we=1 for exactly this cycle; write commits at the closing posedge
//    RESP -> IDLE: ack=1 (err as computed), busy=1 in RESP
//  - Latency from accept edge to ack cycle: load 2, SW 2, SB/SH 3, illegal 1.
//  - A back-to-back req is accepted in the cycle after RESP (IDLE).
//  - Lane select: byte = addr_q[1:0]*8; half = addr_q[1]*16. LB/LH sign-extend; LBU/LHU zero-extend.
//  - SW: mem_wdata=wdata_q. SB/SH: mem_wdata=merge_q.
//  - mem_addr is driven from addr_q in LD/RMW_RD/WR and otherwise holds its last value.
//  - mem_we = (state==WR) & ~rst (combinational): reset in a WR cycle suppresses the write.
//  - Reset in any state returns to IDLE next edge; no ack is issued for the aborted request.
//  - On err: rdata=0, no mem_we pulse, memory unchanged.
// TESTING
//  1. SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> one mem_we pulse at word 4; ack 2 cycles after each accept; rdata=0xDEADBEEF.
//  2. After test 1, SB addr=0x11 wdata=0x55 -> RMW; word 4 becomes 0xDEAD55EF; ack after 3 cycles.
//  3. LB 0x13 -> rdata=0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
//  4. LW 0x02 and SH 0x01 -> ack with err=1 after 1 cycle, mem_we never high, word 0 unchanged.
//  5. req held high for 5 cycles with LW -> second accept only in the cycle after the first ack; busy high in between.
//  6. SB started, rst=1 during the WR cycle -> mem_we stays 0, target word unchanged, no ack, IDLE next cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: maps byte-addressed RV32I loads and stores onto a word-organised dmem.
// Sub-word stores use a read-modify-write; loads are lane-extracted and sign/zero-extended.
// Illegal or misaligned accesses complete with err and never touch memory.
module load_store_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            ack,
  output logic            err,
  output logic [XLEN-1:0] rdata,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StLd,
    StRmwRd,
    StWr,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic [2:0]      funct3_q;
  logic [AW+1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            err_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] merge_q;
  logic [AW-1:0]   mem_addr_q;

  logic            illegal;
  logic            accept;
  logic            mem_state;
  logic [4:0]      byte_off;
  logic [4:0]      half_off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] ld_ext;
  logic [XLEN-1:0] merge;

  // Address bits above the dmem window are intentionally dropped (the index wraps).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[XLEN-1:AW+2];

  assign accept    = (state_q == StIdle) && req;
  assign mem_state = (state_q == StLd) || (state_q == StRmwRd) || (state_q == StWr);
  assign byte_off  = {addr_q[1:0], 3'b000};
  assign half_off  = {addr_q[1], 4'b0000};
  assign byte_sel  = mem_rdata[byte_off +: 8];
  assign half_sel  = mem_rdata[half_off +: 16];

  // Legality of the incoming request: funct3 encoding, store width and alignment.
  always_comb begin
    illegal = 1'b0;
    unique case (funct3)
      3'b000:         illegal = 1'b0;
      3'b001:         illegal = addr[0];
      3'b010:         illegal = |addr[1:0];
      3'b100, 3'b101: illegal = we || (funct3[0] && addr[0]);
      default:        illegal = 1'b1;
    endcase
  end

  // Load lane extraction with sign/zero extension.
  always_comb begin
    ld_ext = mem_rdata;
    unique case (funct3_q)
      3'b000:  ld_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  ld_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, half_sel};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Replace the addressed byte/half of the read word with the store data.
  always_comb begin
    merge = mem_rdata;
    unique case (funct3_q[1:0])
      2'b00:   merge[byte_off +: 8]  = wdata_q[7:0];
      2'b01:   merge[half_off +: 16] = wdata_q[15:0];
      default: merge = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (illegal) begin
            state_d = StResp;
          end else if (!we) begin
            state_d = StLd;
          end else if (funct3[1:0] == 2'b10) begin
            state_d = StWr;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StLd:    state_d = StResp;
      StRmwRd: state_d = StWr;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; mem_we is gated by rst so a reset in the write cycle drops the write.
  always_comb begin
    busy      = (state_q != StIdle);
    ack       = (state_q == StResp);
    err       = ack && err_q;
    rdata     = rdata_q;
    mem_we    = (state_q == StWr) && !rst;
    mem_addr  = mem_state ? addr_q[AW+1:2] : mem_addr_q;
    mem_wdata = '0;
    if (state_q == StWr) begin
      mem_wdata = (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;
    end
  end

  // Request capture, load result, merge word and held memory address.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      merge_q    <= '0;
      mem_addr_q <= '0;
    end else begin
      if (accept) begin
        funct3_q <= funct3;
        addr_q   <= addr[AW+1:0];
        wdata_q  <= wdata;
        err_q    <= illegal;
        if (illegal) begin
          rdata_q <= '0;
        end
      end
      if (state_q == StLd) begin
        rdata_q <= ld_ext;
      end
      if (state_q == StRmwRd) begin
        merge_q <= merge;
      end
      if (mem_state) begin
        mem_addr_q <= addr_q[AW+1:2];
      end
    end
  end

endmodule
